// File: rtl/ltl_monitor_pkg.sv
// Shared defaults and the report entry type for the LTL monitor report path.
`default_nettype none

package ltl_monitor_pkg;

  localparam int LTL_NUM_RPT = 4;
  localparam int LTL_IDX_W   = 16;
  localparam int LTL_DROP_W  = 8;
  localparam int LTL_DEPTH   = 8;

  typedef struct packed {
    logic [LTL_IDX_W-1:0]   idx;
    logic [LTL_NUM_RPT-1:0] vec;
  } rpt_entry_t;

endpackage

`default_nettype wire

// File: rtl/ltl_rpt_fifo.sv
// Power-of-two circular FIFO for timestamped report entries; no drop policy here.
`default_nettype none

module ltl_rpt_fifo
  import ltl_monitor_pkg::*;
#(
  parameter int  DEPTH   = LTL_DEPTH,
  parameter type entry_t = rpt_entry_t
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  entry_t                     wdata_i,
  input  logic                       pop_i,
  output entry_t                     rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  entry_t           mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + (PTR_W+1)'(1);
        2'b01:   level_d = level_q - (PTR_W+1)'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!clear_i && do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ltl_report_collector.sv
// Timestamps non-zero LTL automaton reports, queues them and tracks drops.
// Optional macro LTL_REPORT_MASK_EN adds rpt_mask, latched into mask_q on clear.
`default_nettype none

module ltl_report_collector
  import ltl_monitor_pkg::*;
#(
  parameter int NUM_RPT = LTL_NUM_RPT,
  parameter int DEPTH   = LTL_DEPTH,
  parameter int IDX_W   = LTL_IDX_W,
  parameter int DROP_W  = LTL_DROP_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic                     clear,
  input  logic [NUM_RPT-1:0]       report_in,
`ifdef LTL_REPORT_MASK_EN
  input  logic [NUM_RPT-1:0]       rpt_mask,
`endif
  output logic                     rpt_valid,
  input  logic                     rpt_ready,
  output logic [IDX_W-1:0]         rpt_idx,
  output logic [NUM_RPT-1:0]       rpt_vec,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt
);

  typedef struct packed {
    logic [IDX_W-1:0]   idx;
    logic [NUM_RPT-1:0] vec;
  } entry_t;

  logic               run_q, run_d;
  logic [IDX_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic [IDX_W-1:0]   sym_idx_q, sym_idx_d;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic [NUM_RPT-1:0] eff_vec;
  logic               push_req;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               fifo_full;
  logic               fifo_empty;
  entry_t             wr_entry;
  entry_t             head;

`ifdef LTL_REPORT_MASK_EN
  logic [NUM_RPT-1:0] mask_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   mask_q <= '1;
    else if (clear) mask_q <= rpt_mask;
  end

  assign eff_vec = report_in & mask_q;
`else
  assign eff_vec = report_in;
`endif

  // The automata answer one cycle after run, so run_q qualifies report_in.
  assign push_req = run_q && (eff_vec != '0);
  assign pop      = rpt_valid && rpt_ready;
  assign push_ok  = !clear && push_req && (!fifo_full || pop);
  assign drop     = !clear && push_req && !push_ok;

  assign wr_entry.idx = sym_idx_q;
  assign wr_entry.vec = eff_vec;

  always_comb begin
    run_d      = run;
    sym_cnt_d  = sym_cnt_q;
    sym_idx_d  = sym_idx_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      run_d      = 1'b0;
      sym_cnt_d  = '0;
      sym_idx_d  = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (run) begin
        sym_idx_d = sym_cnt_q;
        sym_cnt_d = sym_cnt_q + IDX_W'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q      <= 1'b0;
      sym_cnt_q  <= '0;
      sym_idx_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      run_q      <= run_d;
      sym_cnt_q  <= sym_cnt_d;
      sym_idx_q  <= sym_idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  ltl_rpt_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (clear),
    .push_i  (push_ok),
    .wdata_i (wr_entry),
    .pop_i   (pop && !clear),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rpt_valid = !fifo_empty;
  assign rpt_idx   = head.idx;
  assign rpt_vec   = head.vec;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ltl_report_collector.sv
// Directed bench: default-parameter instance plus a narrow instance (IDX_W=4, DROP_W=2).
`default_nettype none

module tb_ltl_report_collector;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       run;
  logic       clear;
  logic [3:0] report_in;
  logic [3:0] rpt_mask;
  logic       rpt_ready;

  logic        v_d, v_s;
  logic [15:0] idx_d;
  logic [3:0]  idx_s;
  logic [3:0]  vec_d, vec_s;
  logic [3:0]  lvl_d, lvl_s;
  logic        ovf_d, ovf_s;
  logic [7:0]  drp_d;
  logic [1:0]  drp_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ltl_report_collector dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .clear      (clear),
    .report_in  (report_in),
`ifdef LTL_REPORT_MASK_EN
    .rpt_mask   (rpt_mask),
`endif
    .rpt_valid  (v_d),
    .rpt_ready  (rpt_ready),
    .rpt_idx    (idx_d),
    .rpt_vec    (vec_d),
    .fifo_level (lvl_d),
    .overflow   (ovf_d),
    .drop_cnt   (drp_d)
  );

  ltl_report_collector #(.IDX_W(4), .DROP_W(2)) dut_s (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .clear      (clear),
    .report_in  (report_in),
`ifdef LTL_REPORT_MASK_EN
    .rpt_mask   (rpt_mask),
`endif
    .rpt_valid  (v_s),
    .rpt_ready  (rpt_ready),
    .rpt_idx    (idx_s),
    .rpt_vec    (vec_s),
    .fifo_level (lvl_s),
    .overflow   (ovf_s),
    .drop_cnt   (drp_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse(input logic [3:0] mask);
    rpt_mask  = mask;
    clear     = 1'b1;
    run       = 1'b0;
    report_in = '0;
    step();
    clear     = 1'b0;
    rpt_mask  = 4'hF;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; clear = 1'b0; report_in = '0;
    rpt_mask = 4'hF; rpt_ready = 1'b0;

    // Reset and idle
    #2;
    check("rst_valid", v_d, 0);
    check("rst_level", lvl_d, 0);
    step(); step();
    reset_n = 1'b1;
    repeat (10) step();
    check("idle_valid", v_d, 0);
    check("idle_level", lvl_d, 0);
    check("idle_ovf", ovf_d, 0);
    check("idle_drop", drp_d, 0);

    // Single report for symbol 3
    for (int i = 0; i < 6; i++) begin
      run       = (i < 5);
      report_in = (i == 4) ? 4'b0100 : 4'b0000;
      step();
      if (i == 3) check("single_valid_t1", v_d, 0);
      if (i == 4) begin
        check("single_valid_t2", v_d, 1);
        check("single_idx", idx_d, 3);
        check("single_vec", vec_d, 4'b0100);
        check("single_level", lvl_d, 1);
      end
    end
    check("single_level_hold", lvl_d, 1);
    rpt_ready = 1'b1;
    step();
    rpt_ready = 1'b0;
    check("single_pop_valid", v_d, 0);
    check("single_pop_level", lvl_d, 0);

    // Full then drop
    clear_pulse(4'hF);
    for (int i = 0; i < 11; i++) begin
      run       = (i < 10);
      report_in = (i >= 1) ? 4'b1000 : 4'b0000;
      step();
    end
    run = 1'b0; report_in = '0;
    check("full_level", lvl_d, 8);
    check("full_ovf", ovf_d, 1);
    check("full_drop", drp_d, 2);
    check("full_drop_s", drp_s, 2);
    rpt_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("full_drain_valid_%0d", k), v_d, 1);
      check($sformatf("full_drain_idx_%0d", k), idx_d, k);
      step();
    end
    rpt_ready = 1'b0;
    check("full_empty_valid", v_d, 0);
    check("full_empty_level", lvl_d, 0);

    // Simultaneous push and pop while full
    clear_pulse(4'hF);
    for (int i = 0; i < 10; i++) begin
      run       = (i < 9);
      report_in = (i >= 1) ? 4'b1000 : 4'b0000;
      rpt_ready = (i == 9);
      step();
    end
    run = 1'b0; report_in = '0; rpt_ready = 1'b0;
    check("pp_level", lvl_d, 8);
    check("pp_head", idx_d, 1);
    check("pp_drop", drp_d, 0);
    check("pp_ovf", ovf_d, 0);
    rpt_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("pp_drain_idx_%0d", k), idx_d, k);
      step();
    end
    rpt_ready = 1'b0;
    check("pp_empty_level", lvl_d, 0);

    // Index wrap on the narrow instance, drained every cycle
    clear_pulse(4'hF);
    rpt_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      run       = (i < 20);
      report_in = (i >= 1) ? 4'b0001 : 4'b0000;
      step();
      if (i >= 1) check($sformatf("wrap_idx_s_%0d", i), idx_s, (i - 1) % 16);
      if (i == 17) check("wrap_idx_d_17", idx_d, 16);
    end
    run = 1'b0; report_in = '0;
    step();
    rpt_ready = 1'b0;
    check("wrap_level", lvl_d, 0);
    check("wrap_drop", drp_d, 0);

    // Drop counter saturation
    clear_pulse(4'hF);
    for (int i = 0; i < 15; i++) begin
      run       = (i < 14);
      report_in = (i >= 1) ? 4'b0010 : 4'b0000;
      step();
    end
    run = 1'b0; report_in = '0;
    check("sat_drop_s", drp_s, 3);
    check("sat_drop_d", drp_d, 6);
    check("sat_ovf_s", ovf_s, 1);
    check("sat_level", lvl_d, 8);

    // Clear mid-traffic with a report pending
    rpt_ready = 1'b1;
    repeat (3) step();
    rpt_ready = 1'b0;
    check("clr_pre_level", lvl_d, 5);
    check("clr_pre_head", idx_d, 3);
    run = 1'b1;
    step();
    clear = 1'b1; run = 1'b1; report_in = 4'b0010; rpt_mask = 4'b0001;
    step();
    clear = 1'b0; rpt_mask = 4'hF; report_in = '0; run = 1'b1;
    check("clr_level", lvl_d, 0);
    check("clr_ovf", ovf_d, 0);
    check("clr_drop", drp_d, 0);
    check("clr_valid", v_d, 0);
    step();
    run = 1'b0; report_in = 4'b0010;
    step();
    report_in = '0;
`ifdef LTL_REPORT_MASK_EN
    check("clr_masked_valid", v_d, 0);
    check("clr_masked_level", lvl_d, 0);
    check("clr_masked_drop", drp_d, 0);
`else
    check("clr_next_valid", v_d, 1);
    check("clr_next_idx", idx_d, 0);
    check("clr_next_vec", vec_d, 4'b0010);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
